// File: rtl/sched_pkg.sv
// Shared types and constants for the dual-issue front end.
// Bundle layout, queue entry type and issue FSM states.
package sched_pkg;

  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam int PC_A    = 0;
  localparam int INSTR_A = 32;
  localparam int PC_B    = 64;
  localparam int INSTR_B = 96;

  typedef struct packed {
    logic [127:0] bundle;
    logic         dual;
  } iss_entry_t;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } seq_state_e;

  function automatic logic is_dual(input logic [127:0] b);
    return |b[INSTR_B +: 32];
  endfunction

endpackage

// File: rtl/bundle_fifo.sv
// In-order circular buffer of issue entries: up to 2 writes and 1 read
// per cycle. Ports: clear (sync), push_n (0..2), wr0/wr1, pop, head, count.
module bundle_fifo
  import sched_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [1:0]    push_n,
  input  iss_entry_t    wr0,
  input  iss_entry_t    wr1,
  input  logic          pop,
  output iss_entry_t    head,
  output logic [CW-1:0] count
);

  iss_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_wr1;

  assign w_wr1 = AW'(r_wr + 1'b1);

  always_ff @(posedge clk) begin
    if (!clear && push_n != 2'd0) begin
      r_mem[r_wr] <= wr0;
      if (push_n == 2'd2) begin
        r_mem[w_wr1] <= wr1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= AW'(r_wr + push_n);
      r_rd    <= AW'(r_rd + pop);
      r_count <= r_count + CW'(push_n) - CW'(pop);
    end
  end

  // Empty queue presents an all-zero entry.
  assign head  = (r_count != '0) ? r_mem[r_rd] : '0;
  assign count = r_count;

endmodule

// File: rtl/issue_sequencer.sv
// Registered issue stage: scheduler decisions -> ordered queue -> decode,
// with fetch back-pressure and one-cycle JAL redirect. Opt: ISSUE_SEQ_PERF_EN.
module issue_sequencer
  import sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sched_valid,
  input  logic [4*XLEN-1:0] sched_instr1,
  input  logic [4*XLEN-1:0] sched_instr2,
  input  logic            sched_write1,
  input  logic            sched_write2,
  input  logic            sched_jal,
  input  logic [XLEN-1:0] sched_jal_addr,
  input  logic            flush,
  output logic            fetch_stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_addr,
  output logic            iss_valid,
  input  logic            iss_ready,
  output logic [4*XLEN-1:0] iss_bundle,
  output logic            iss_dual,
`ifdef ISSUE_SEQ_PERF_EN
  output logic [31:0]     perf_dual,
  output logic [31:0]     perf_split,
  output logic [31:0]     perf_redirect,
`endif
  output logic [CW-1:0]   occupancy
);

  seq_state_e      r_state;
  seq_state_e      w_next;
  logic [XLEN-1:0] r_redirect_addr;
  logic            w_accept;
  logic            w_pop;
  logic [1:0]      w_push_n;
  iss_entry_t      w_e0;
  iss_entry_t      w_e1;
  iss_entry_t      w_head;
  logic [CW-1:0]   w_count;
  logic            w_unused;

  assign w_unused = ^sched_instr2[127:64];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN:      if (w_accept && sched_jal) w_next = REDIRECT;
      REDIRECT: w_next = RUN;
      default:  w_next = RUN;
    endcase
    if (flush) w_next = RUN;
  end

  // Stall uses registered count; a same-cycle pop does not free space.
  always_comb begin
    redirect_valid = (r_state == REDIRECT);
    fetch_stall    = redirect_valid | (w_count > CW'(DEPTH - 2));
  end

  assign w_accept = sched_valid & ~fetch_stall & ~flush;
  assign w_pop    = iss_valid & iss_ready & ~flush;

  always_comb begin
    w_push_n = 2'd0;
    w_e0     = '0;
    w_e1     = '0;
    unique case (1'b1)
      w_accept & sched_write2: begin
        w_push_n = 2'd2;
        w_e0     = '{bundle: {64'd0, sched_instr1[63:0]}, dual: 1'b0};
        w_e1     = '{bundle: {64'd0, sched_instr2[63:0]}, dual: 1'b0};
      end
      w_accept & sched_write1 & ~sched_write2: begin
        w_push_n = 2'd1;
        w_e0     = '{bundle: sched_instr1, dual: is_dual(sched_instr1)};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_redirect_addr <= '0;
    else if (w_accept && sched_jal) r_redirect_addr <= sched_jal_addr;
  end

  bundle_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (flush),
    .push_n (w_push_n),
    .wr0    (w_e0),
    .wr1    (w_e1),
    .pop    (w_pop),
    .head   (w_head),
    .count  (w_count)
  );

  assign redirect_addr = r_redirect_addr;
  assign iss_valid     = (w_count != '0);
  assign iss_bundle    = w_head.bundle;
  assign iss_dual      = w_head.dual;
  assign occupancy     = w_count;

`ifdef ISSUE_SEQ_PERF_EN
  logic [31:0] r_perf_dual;
  logic [31:0] r_perf_split;
  logic [31:0] r_perf_redir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_dual  <= '0;
      r_perf_split <= '0;
      r_perf_redir <= '0;
    end else begin
      if (w_pop && iss_dual && r_perf_dual != '1)
        r_perf_dual <= r_perf_dual + 1'b1;
      if (w_accept && sched_write2 && r_perf_split != '1)
        r_perf_split <= r_perf_split + 1'b1;
      if (r_state == RUN && w_next == REDIRECT && r_perf_redir != '1)
        r_perf_redir <= r_perf_redir + 1'b1;
    end
  end

  assign perf_dual     = r_perf_dual;
  assign perf_split    = r_perf_split;
  assign perf_redirect = r_perf_redir;
`endif

endmodule

// File: doc/issue_sequencer.md
Name: issue_sequencer

Overview:
- Registered issue stage between the combinational dual-issue scheduler and decode.
- Converts each scheduler decision into 0, 1 or 2 ordered queue entries: one dual bundle, one single, or a serialised single+single.
- Buffers entries in a small in-order queue and back-pressures fetch.
- Sequences the one-cycle JAL redirect, which includes dropping the wrong-path fetch bundle.

Parameters:
- DEPTH, 4, number of queue entries; power of 2, minimum 2.
- XLEN, 32, PC and instruction width; bundle width is 4*XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sched_valid  in  1  scheduler outputs are valid this cycle.
- sched_instr1  in  128  {instr_b, pc_b, instr_a, pc_a}; upper 64 bits are zero when single.
- sched_instr2  in  128  second serialised instruction in the low 64 bits.
- sched_write1  in  1  push sched_instr1 as one entry.
- sched_write2  in  1  push low64(instr1) then low64(instr2) as two entries.
- sched_jal  in  1  JAL detected in the bundle.
- sched_jal_addr  in  32  JAL target.
- flush  in  1  backend flush (mispredict/exception).
- fetch_stall  out  1  scheduler input is not accepted this cycle.
- redirect_valid  out  1  one-cycle PC redirect pulse.
- redirect_addr  out  32  redirect target.
- iss_valid  out  1  head entry valid.
- iss_ready  in  1  decode accepts head.
- iss_bundle  out  128  head bundle.
- iss_dual  out  1  head carries two instructions (bits 127:96 nonzero).
- occupancy  out  $clog2(DEPTH)+1  registered entry count.

Behaviour:
- Reset (async, rst_n=0):
  - count=0, rd/wr pointers=0, state=RUN.
  - redirect_valid=0, redirect_addr=0, iss_valid=0, iss_bundle=0, iss_dual=0.
- fetch_stall = (state==REDIRECT) | (DEPTH-count < 2). The check uses registered count and ignores a same-cycle pop.
- accept = sched_valid & ~fetch_stall & ~flush.
- Push rules when accept:
  - write1=1: push {instr1, dual=(instr1[127:96]!=0)}.
  - write2=1: push {64'd0, instr1[63:0]} then {64'd0, instr2[63:0]}, both dual=0, in that order in the same cycle.
  - write1 and write2 both 0: no push.
  - write1 and write2 both 1: illegal; write2 wins.
- Pop: iss_valid & iss_ready removes the head.
  - Push and pop may occur in the same cycle; count += pushes - pop.
- Output latency: an entry pushed in cycle N can appear on iss_* at N+1 at the earliest. There is no bypass path.
- Queue empty: iss_valid=0, iss_bundle=0, iss_dual=0.
- Pointers wrap modulo DEPTH.
- FSM:
  - RUN: accept & sched_jal -> REDIRECT; latch redirect_addr=sched_jal_addr. Pushes for that bundle still occur per the rules above.
  - REDIRECT (exactly one cycle): redirect_valid=1; fetch_stall=1, so the wrong-path bundle is dropped; then -> RUN.
  - redirect_valid=0 in RUN.
- Flush (synchronous, highest priority):
  - Clears the queue (count=0, pointers=0); iss_valid=0 next cycle.
  - state -> RUN; any pending redirect is cancelled, so no redirect_valid pulse.
  - No push or pop takes effect in the flush cycle.
- Full: count==DEPTH-1 or DEPTH keeps fetch_stall=1; the queue never overflows.
- Mid-operation reset returns to the reset state immediately.

Optional Feature:
- ISSUE_SEQ_PERF_EN defined adds three 32-bit saturating output counters:
  - perf_dual: popped entries with dual=1.
  - perf_split: accepted write2 events.
  - perf_redirect: REDIRECT entries.
- Counters reset to 0 on rst_n and are unaffected by flush.
- Undefined: these ports and counters are absent.

Decomposition:
- Package sched_pkg:
  - OPC_JAL=7'b1101111, OPC_LOAD=7'b0000011, OPC_STORE=7'b0100011.
  - Bundle field offsets: PC_A=0, INSTR_A=32, PC_B=64, INSTR_B=96.
  - iss_entry_t struct {logic [127:0] bundle; logic dual;}.
  - seq_state_e {RUN, REDIRECT}.
- Sub-module bundle_fifo: 2-write/1-read circular buffer of iss_entry_t, DEPTH-parameterised, exposing count.
- issue_sequencer holds the FSM, push decode and stall logic.

Test Plan:
- Dual push and pop:
  - Stimulus: write1=1, instr1={32'h00208133,32'h104,32'h00100093,32'h100}, iss_ready=1.
  - Response: next cycle iss_valid=1, iss_dual=1, bundle matches; occupancy returns to 0 after pop.
- Serialised split:
  - Stimulus: write2=1, instr1 low=pc 0x200 and instr2 low=pc 0x204, iss_ready=0.
  - Response: occupancy=2; two pops yield pc 0x200 then 0x204, both dual=0.
- JAL redirect:
  - Stimulus: write1=1, jal=1, jal_addr=0x0000_0400, followed by a bundle at pc 0x108.
  - Response: redirect_valid=1 with addr 0x400 for exactly one cycle; fetch_stall=1 in that cycle; the 0x108 bundle is not enqueued.
- Full back-pressure:
  - Stimulus: DEPTH=4, iss_ready=0, three write1 pushes.
  - Response: fetch_stall=1 once count=3; further sched_valid is ignored and occupancy stays 3.
- Flush priority:
  - Stimulus: count=3, flush=1 together with sched_valid, write2 and iss_ready.
  - Response: next cycle occupancy=0, iss_valid=0, no redirect pulse.
- Async reset mid-REDIRECT:
  - Stimulus: rst_n=0 between clock edges.
  - Response: redirect_valid=0 and iss_valid=0 immediately; state=RUN after release.
